mipsmc_ctrl: RTL and testbench
==============================

# mipsmc_ctrl

Parametrised multicycle MIPS control unit for the next-generation multicycle core. It replaces the fixed single-cycle-memory controller, adds four capabilities, and drives the existing multicycle datapath unchanged:
- a ready/valid memory handshake with bounded wait states;
- ANDI and SLTI;
- a defined illegal-instruction/bus-error halt;
- optional performance counters.

It sits between the instruction register fields and the datapath mux/enable controls.

## Interface
Parameters:
- MEM_TIMEOUT, 16: max cycles any memory state waits for mem_ready before bus error (≥1)
- CNT_W, 32: width of perf counters

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag (combinational from current ALU result)
- mem_ready  in  1  memory completed the current access this cycle
- memread  out  1  fetch/load request
- memwrite  out  1  store request
- pcen, irwrite, regwrite  out  1 each  datapath write enables
- alusrca, iord, memtoreg, regdst, jal  out  1 each  mux selects, meanings as datapath
- pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
- alusrcb  out  3  000 B, 001 4, 010 signimm, 011 signimm<<2, 1xx zeroimm
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- halted  out  1  controller in HALT
- illegal  out  1  sticky: HALT entered on undecoded op/funct
- bus_err  out  1  sticky: HALT entered on memory timeout
- state_o  out  5  current state code (debug)
- instret, cycles  out  CNT_W each  perf counters (zero when counters compiled out)

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BEQEX, BNEEX, ADDIEX, ANDIEX, ORIEX, SLTIEX, IWB, JEX, JALEX, JREX, HALT.
- Outputs are Moore, except irwrite/PC write in FETCH and pcen in BEQEX/BNEEX, which are Mealy on mem_ready/zero.
- All outputs not listed for a state are 0; alucontrol defaults to 010.
- FETCH:
  - memread=1, iord=0, alusrca=0, alusrcb=001, pcsrc=00.
  - irwrite=pcen=mem_ready; advance to DECODE only when mem_ready=1.
- DECODE: alusrcb=011 (branch target into ALUOut). Next state by op:
  - lw/sw→MEMADR; beq→BEQEX; bne→BNEEX.
  - addi/andi(001100)/ori/slti(001010)→own EX state.
  - j→JEX; jal→JALEX.
  - op 0: funct 001000→JREX; add/sub/and/or/slt→RTYPEEX.
  - Any other op or funct→HALT with illegal set.
- MEMADR: alusrca=1, alusrcb=010; next state MEMRD (lw) or MEMWR (sw).
- MEMRD: memread=1, iord=1; →MEMWB on mem_ready.
- MEMWB: regwrite=1, memtoreg=1, regdst=0; →FETCH.
- MEMWR: memwrite=1, iord=1; →FETCH on mem_ready.
- RTYPEEX: alusrca=1, alusrcb=000, alucontrol from funct; →RTYPEWB.
- RTYPEWB: regwrite=1, regdst=1; →FETCH.
- Branches (BEQEX/BNEEX): alusrca=1, alusrcb=000, alucontrol=110, pcsrc=01.
  - pcen = zero (beq) or ~zero (bne); →FETCH.
- Immediate EX states (alusrca=1):
  - ADDIEX: alusrcb=010, add.
  - ANDIEX: alusrcb=100, and.
  - ORIEX: alusrcb=100, or.
  - SLTIEX: alusrcb=010, slt.
  - All →IWB.
- IWB: regwrite=1, regdst=0; →FETCH.
- JEX: pcen=1, pcsrc=10.
- JALEX: pcen=1, pcsrc=10, jal=1, regwrite=1 (r31←PC).
- JREX: pcen=1, pcsrc=11.
- Wait counter:
  - Clears on entry to FETCH/MEMRD/MEMWR; increments each cycle in those states with mem_ready=0.
  - On reaching MEM_TIMEOUT with mem_ready=0: →HALT with bus_err set, no write enables that cycle.
  - mem_ready=1 on the timeout cycle wins.
- HALT: all enables and requests 0, halted=1; leaves only on reset.

## Timing
- Reset (async assert) values:
  - state=FETCH, memread=1, all other outputs 0 (pcen/irwrite follow mem_ready, so 0 while mem_ready=0).
  - Counters, illegal and bus_err are 0.
- Reset mid-access abandons the access; no write enable is asserted in the reset cycle.
- Latency at zero wait states:
  - lw 5 cycles; sw, R-type, immediate ops 4; branches and jumps 3.
  - Each wait cycle adds 1.
- mem_ready is sampled only in FETCH/MEMRD/MEMWR and ignored elsewhere.

## Configuration
- MIPSMC_PERFCNT_EN defined:
  - cycles increments every non-HALT cycle.
  - instret increments on every transition into FETCH from a completing state.
  - Both wrap modulo 2^CNT_W.
- Undefined: no counter flops; instret and cycles tie to 0.

## Test plan
- Reset, mem_ready=1, addi: states FETCH→DECODE→ADDIEX→IWB→FETCH; regwrite=1 only in IWB; instret=1 after 4 cycles.
- lw with mem_ready held low 3 cycles in MEMRD (MEM_TIMEOUT=16): 3 wait cycles, memread=1, iord=1 throughout; total 8 cycles.
- bne with zero=1 → pcen=0; repeat with zero=0 → pcen=1, pcsrc=01.
- op=111111 in DECODE → HALT, illegal=1, halted=1; no write enable for 20 cycles; reset_n low clears.
- mem_ready never asserted in FETCH, MEM_TIMEOUT=4 → bus_err=1 after 4 cycles; irwrite/pcen never 1.
- CNT_W=4 with counters enabled, 16 one-wait-free R-type ops → instret wraps to 0.

Source files
------------

// File: rtl/mipsmc_ctrl.sv
// Multicycle MIPS control unit: ready/valid memory wait states, illegal-op and bus-error halt.
// Define MIPSMC_PERFCNT_EN to build the instret/cycles performance counters.
module mipsmc_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             memread,
    output logic             memwrite,
    output logic             pcen,
    output logic             irwrite,
    output logic             regwrite,
    output logic             alusrca,
    output logic             iord,
    output logic             memtoreg,
    output logic             regdst,
    output logic             jal,
    output logic [1:0]       pcsrc,
    output logic [2:0]       alusrcb,
    output logic [2:0]       alucontrol,
    output logic             halted,
    output logic             illegal,
    output logic             bus_err,
    output logic [4:0]       state_o,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [4:0] {
        S_FETCH   = 5'd0,
        S_DECODE  = 5'd1,
        S_MEMADR  = 5'd2,
        S_MEMRD   = 5'd3,
        S_MEMWB   = 5'd4,
        S_MEMWR   = 5'd5,
        S_RTYPEEX = 5'd6,
        S_RTYPEWB = 5'd7,
        S_BEQEX   = 5'd8,
        S_BNEEX   = 5'd9,
        S_ADDIEX  = 5'd10,
        S_ANDIEX  = 5'd11,
        S_ORIEX   = 5'd12,
        S_SLTIEX  = 5'd13,
        S_IWB     = 5'd14,
        S_JEX     = 5'd15,
        S_JALEX   = 5'd16,
        S_JREX    = 5'd17,
        S_HALT    = 5'd18
    } state_t;

    state_t            state, next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_state;
    logic              timeout;

    // Undecodable op/funct resolves to HALT; the caller flags it as illegal.
    function automatic state_t decode_next(input logic [5:0] op_i, input logic [5:0] funct_i);
        state_t ns;
        case (op_i)
            OP_LW, OP_SW: ns = S_MEMADR;
            OP_BEQ:       ns = S_BEQEX;
            OP_BNE:       ns = S_BNEEX;
            OP_ADDI:      ns = S_ADDIEX;
            OP_ANDI:      ns = S_ANDIEX;
            OP_ORI:       ns = S_ORIEX;
            OP_SLTI:      ns = S_SLTIEX;
            OP_J:         ns = S_JEX;
            OP_JAL:       ns = S_JALEX;
            OP_RTYPE: begin
                case (funct_i)
                    F_JR:                            ns = S_JREX;
                    F_ADD, F_SUB, F_AND, F_OR, F_SLT: ns = S_RTYPEEX;
                    default:                         ns = S_HALT;
                endcase
            end
            default:      ns = S_HALT;
        endcase
        return ns;
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] funct_i);
        logic [2:0] a;
        case (funct_i)
            F_SUB:   a = ALU_SUB;
            F_AND:   a = ALU_AND;
            F_OR:    a = ALU_OR;
            F_SLT:   a = ALU_SLT;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    // A ready on the last allowed cycle still completes the access.
    assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= (mem_state && !mem_ready) ? wait_cnt + WAIT_W'(1) : '0;
            if (state == S_DECODE && next_state == S_HALT)
                illegal <= 1'b1;
            if (timeout)
                bus_err <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (timeout) next_state = S_HALT;
            end
            S_DECODE:  next_state = decode_next(op, funct);
            S_MEMADR:  next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)    next_state = S_MEMWB;
                else if (timeout) next_state = S_HALT;
            end
            S_MEMWR: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (timeout) next_state = S_HALT;
            end
            S_RTYPEEX: next_state = S_RTYPEWB;
            S_ADDIEX, S_ANDIEX, S_ORIEX, S_SLTIEX: next_state = S_IWB;
            S_MEMWB, S_RTYPEWB, S_IWB, S_BEQEX, S_BNEEX,
            S_JEX, S_JALEX, S_JREX: next_state = S_FETCH;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_HALT;
        endcase
    end

    always_comb begin
        memread    = 1'b0;
        memwrite   = 1'b0;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        jal        = 1'b0;
        pcsrc      = 2'b00;
        alusrcb    = 3'b000;
        alucontrol = ALU_ADD;
        case (state)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = 3'b001;
                irwrite = mem_ready;
                pcen    = mem_ready;
            end
            S_DECODE:  alusrcb = 3'b011;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = rtype_alu(funct);
            end
            S_RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BEQEX, S_BNEEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen       = (state == S_BEQEX) ? zero : ~zero;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 3'b010;
            end
            S_ANDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b100;
                alucontrol = ALU_AND;
            end
            S_ORIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b100;
                alucontrol = ALU_OR;
            end
            S_SLTIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 3'b010;
                alucontrol = ALU_SLT;
            end
            S_IWB:     regwrite = 1'b1;
            S_JEX: begin
                pcen  = 1'b1;
                pcsrc = 2'b10;
            end
            S_JALEX: begin
                pcen     = 1'b1;
                pcsrc    = 2'b10;
                jal      = 1'b1;
                regwrite = 1'b1;
            end
            S_JREX: begin
                pcen  = 1'b1;
                pcsrc = 2'b11;
            end
            default: ;
        endcase
    end

    assign halted  = (state == S_HALT);
    assign state_o = state;

`ifdef MIPSMC_PERFCNT_EN
    logic [CNT_W-1:0] instret_q, cycles_q;
    logic             retire;

    // Only completing states can move into FETCH; HALT never does.
    assign retire = (next_state == S_FETCH) && (state != S_FETCH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (state != S_HALT)
                cycles_q <= cycles_q + CNT_W'(1);
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign instret = instret_q;
    assign cycles  = cycles_q;
`else
    assign instret = '0;
    assign cycles  = '0;
`endif

endmodule

// File: tb/tb_mipsmc_ctrl.sv
// Directed, table-driven bench for mipsmc_ctrl (MEM_TIMEOUT=4, CNT_W=4).
module tb_mipsmc_ctrl;

    localparam int TB_CNT_W = 4;

    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                           OP_SLTI = 6'b001010, OP_ANDI = 6'b001100, OP_ORI = 6'b001101,
                           OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;

    localparam logic [4:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                           S_MEMWR = 5, S_RTYPEEX = 6, S_RTYPEWB = 7, S_BEQEX = 8, S_BNEEX = 9,
                           S_ADDIEX = 10, S_ANDIEX = 11, S_ORIEX = 12, S_SLTIEX = 13, S_IWB = 14,
                           S_JEX = 15, S_JALEX = 16, S_JREX = 17, S_HALT = 18;

    // {memread,memwrite,pcen,irwrite,regwrite,alusrca,iord,memtoreg,regdst,jal,pcsrc,alusrcb,alucontrol,halted}
    localparam logic [18:0]
        C_FETCH_R = {10'b1011000000, 2'b00, 3'b001, 3'b010, 1'b0},
        C_FETCH_W = {10'b1000000000, 2'b00, 3'b001, 3'b010, 1'b0},
        C_DECODE  = {10'b0000000000, 2'b00, 3'b011, 3'b010, 1'b0},
        C_MEMADR  = {10'b0000010000, 2'b00, 3'b010, 3'b010, 1'b0},
        C_MEMRD   = {10'b1000001000, 2'b00, 3'b000, 3'b010, 1'b0},
        C_MEMWB   = {10'b0000100100, 2'b00, 3'b000, 3'b010, 1'b0},
        C_MEMWR   = {10'b0100001000, 2'b00, 3'b000, 3'b010, 1'b0},
        C_RADD    = {10'b0000010000, 2'b00, 3'b000, 3'b010, 1'b0},
        C_RSUB    = {10'b0000010000, 2'b00, 3'b000, 3'b110, 1'b0},
        C_RAND    = {10'b0000010000, 2'b00, 3'b000, 3'b000, 1'b0},
        C_ROR     = {10'b0000010000, 2'b00, 3'b000, 3'b001, 1'b0},
        C_RSLT    = {10'b0000010000, 2'b00, 3'b000, 3'b111, 1'b0},
        C_RWB     = {10'b0000100010, 2'b00, 3'b000, 3'b010, 1'b0},
        C_BR_T    = {10'b0010010000, 2'b01, 3'b000, 3'b110, 1'b0},
        C_BR_N    = {10'b0000010000, 2'b01, 3'b000, 3'b110, 1'b0},
        C_ADDI    = {10'b0000010000, 2'b00, 3'b010, 3'b010, 1'b0},
        C_ANDI    = {10'b0000010000, 2'b00, 3'b100, 3'b000, 1'b0},
        C_ORI     = {10'b0000010000, 2'b00, 3'b100, 3'b001, 1'b0},
        C_SLTI    = {10'b0000010000, 2'b00, 3'b010, 3'b111, 1'b0},
        C_IWB     = {10'b0000100000, 2'b00, 3'b000, 3'b010, 1'b0},
        C_J       = {10'b0010000000, 2'b10, 3'b000, 3'b010, 1'b0},
        C_JAL     = {10'b0010100001, 2'b10, 3'b000, 3'b010, 1'b0},
        C_JR      = {10'b0010000000, 2'b11, 3'b000, 3'b010, 1'b0},
        C_HALT    = {10'b0000000000, 2'b00, 3'b000, 3'b010, 1'b1};

    logic clk, reset_n, zero, mem_ready;
    logic [5:0] op, funct;
    logic memread, memwrite, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, jal;
    logic [1:0] pcsrc;
    logic [2:0] alusrcb, alucontrol;
    logic halted, illegal, bus_err;
    logic [4:0] state_o;
    logic [TB_CNT_W-1:0] instret, cycles;

    mipsmc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .memread(memread), .memwrite(memwrite), .pcen(pcen), .irwrite(irwrite), .regwrite(regwrite),
        .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .jal(jal),
        .pcsrc(pcsrc), .alusrcb(alusrcb), .alucontrol(alucontrol), .halted(halted),
        .illegal(illegal), .bus_err(bus_err), .state_o(state_o), .instret(instret), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [4:0]  st;
        logic [18:0] ctl;
        logic [1:0]  flg;
    } vec_t;

    vec_t tbl[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [18:0] ctl_now();
        return {memread, memwrite, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst, jal,
                pcsrc, alusrcb, alucontrol, halted};
    endfunction

    function automatic logic [31:0] cexp(input int n);
`ifdef MIPSMC_PERFCNT_EN
        return 32'(n % (1 << TB_CNT_W));
`else
        return 32'd0;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic v(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r,
                     input logic [4:0] s, input logic [18:0] c, input logic [1:0] fl = 2'b00);
        vec_t e;
        e.op = o; e.funct = f; e.zero = z; e.rdy = r; e.st = s; e.ctl = c; e.flg = fl;
        tbl.push_back(e);
    endtask

    task automatic rt(input logic [5:0] f, input logic [18:0] exctl);
        v(OP_R, f, 0, 1, S_FETCH,   C_FETCH_R);
        v(OP_R, f, 1, 1, S_DECODE,  C_DECODE);
        v(OP_R, f, 1, 0, S_RTYPEEX, exctl);
        v(OP_R, f, 0, 1, S_RTYPEWB, C_RWB);
    endtask

    task automatic imm(input logic [5:0] o, input logic [4:0] exs, input logic [18:0] exctl);
        v(o, 6'h15, 0, 1, S_FETCH,  C_FETCH_R);
        v(o, 6'h15, 0, 0, S_DECODE, C_DECODE);
        v(o, 6'h15, 1, 1, exs,      exctl);
        v(o, 6'h15, 0, 0, S_IWB,    C_IWB);
    endtask

    task automatic do_rst();
        reset_n = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic z, input logic r);
        op = o; funct = f; zero = z; mem_ready = r;
        #1;
    endtask

    initial begin
        int nonhalt;
        reset_n = 1'b0; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;

        // addi, lw with 3 MEMRD waits (ready on the last allowed cycle), sw with a fetch wait
        imm(OP_ADDI, S_ADDIEX, C_ADDI);
        v(OP_LW, 0, 0, 1, S_FETCH,  C_FETCH_R);
        v(OP_LW, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_LW, 0, 0, 1, S_MEMADR, C_MEMADR);
        v(OP_LW, 0, 0, 0, S_MEMRD,  C_MEMRD);
        v(OP_LW, 0, 0, 0, S_MEMRD,  C_MEMRD);
        v(OP_LW, 0, 0, 0, S_MEMRD,  C_MEMRD);
        v(OP_LW, 0, 0, 1, S_MEMRD,  C_MEMRD);
        v(OP_LW, 0, 0, 0, S_MEMWB,  C_MEMWB);
        v(OP_SW, 0, 0, 0, S_FETCH,  C_FETCH_W);
        v(OP_SW, 0, 0, 1, S_FETCH,  C_FETCH_R);
        v(OP_SW, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_SW, 0, 0, 1, S_MEMADR, C_MEMADR);
        v(OP_SW, 0, 0, 0, S_MEMWR,  C_MEMWR);
        v(OP_SW, 0, 0, 1, S_MEMWR,  C_MEMWR);
        rt(6'b100000, C_RADD);
        rt(6'b100010, C_RSUB);
        rt(6'b100100, C_RAND);
        rt(6'b100101, C_ROR);
        rt(6'b101010, C_RSLT);
        v(OP_BEQ, 0, 0, 1, S_FETCH, C_FETCH_R); v(OP_BEQ, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_BEQ, 0, 1, 0, S_BEQEX, C_BR_T);
        v(OP_BEQ, 0, 0, 1, S_FETCH, C_FETCH_R); v(OP_BEQ, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_BEQ, 0, 0, 1, S_BEQEX, C_BR_N);
        v(OP_BNE, 0, 0, 1, S_FETCH, C_FETCH_R); v(OP_BNE, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_BNE, 0, 1, 0, S_BNEEX, C_BR_N);
        v(OP_BNE, 0, 0, 1, S_FETCH, C_FETCH_R); v(OP_BNE, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_BNE, 0, 0, 1, S_BNEEX, C_BR_T);
        imm(OP_ANDI, S_ANDIEX, C_ANDI);
        imm(OP_ORI,  S_ORIEX,  C_ORI);
        imm(OP_SLTI, S_SLTIEX, C_SLTI);
        v(OP_J,   0, 0, 1, S_FETCH, C_FETCH_R); v(OP_J,   0, 0, 0, S_DECODE, C_DECODE);
        v(OP_J,   0, 0, 0, S_JEX,   C_J);
        v(OP_JAL, 0, 0, 1, S_FETCH, C_FETCH_R); v(OP_JAL, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_JAL, 0, 0, 0, S_JALEX, C_JAL);
        v(OP_R, 6'b001000, 0, 1, S_FETCH, C_FETCH_R); v(OP_R, 6'b001000, 0, 0, S_DECODE, C_DECODE);
        v(OP_R, 6'b001000, 0, 0, S_JREX,  C_JR);
        v(OP_BAD, 0, 0, 1, S_FETCH, C_FETCH_R); v(OP_BAD, 0, 0, 0, S_DECODE, C_DECODE);
        v(OP_BAD, 0, 0, 1, S_HALT, C_HALT, 2'b10);
        v(OP_BAD, 0, 1, 0, S_HALT, C_HALT, 2'b10);

        nonhalt = 0;
        foreach (tbl[k]) if (tbl[k].st != S_HALT) nonhalt++;

        // Reset values, sampled while reset_n is held low
        repeat (2) @(negedge clk);
        #1;
        chk("rst_state",   32'(state_o), 32'(S_FETCH));
        chk("rst_ctl",     32'(ctl_now()), 32'(C_FETCH_W));
        chk("rst_illegal", 32'(illegal), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_instret", 32'(instret), 0);
        chk("rst_cycles",  32'(cycles), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].rdy);
            if (i == 4) begin
                chk("addi_instret", 32'(instret), cexp(1));
                chk("addi_cycles",  32'(cycles),  cexp(4));
            end
            chk($sformatf("state[%0d]", i), 32'(state_o), 32'(tbl[i].st));
            chk($sformatf("ctl[%0d]", i),   32'(ctl_now()), 32'(tbl[i].ctl));
            chk($sformatf("flags[%0d]", i), 32'({illegal, bus_err}), 32'(tbl[i].flg));
            @(negedge clk);
        end

        // Parked in HALT: nothing enabled, counters frozen (18 instructions retired)
        for (int i = 0; i < 20; i++) begin
            drive(OP_BAD, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("halt_enables", 32'({pcen, irwrite, regwrite, memwrite, memread}), 0);
            chk("halt_halted",  32'(halted), 1);
            @(negedge clk);
        end
        chk("halt_instret", 32'(instret), cexp(18));
        chk("halt_cycles",  32'(cycles),  cexp(nonhalt));

        reset_n = 1'b0;
        #1;
        chk("arst_state",   32'(state_o), 32'(S_FETCH));
        chk("arst_illegal", 32'(illegal), 0);
        chk("arst_halted",  32'(halted), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Fetch never served: bus error after MEM_TIMEOUT cycles
        for (int i = 0; i < 4; i++) begin
            drive(OP_ADDI, 0, 0, 0);
            chk($sformatf("to_state[%0d]", i), 32'(state_o), 32'(S_FETCH));
            chk($sformatf("to_we[%0d]", i), 32'({pcen, irwrite}), 0);
            @(negedge clk);
        end
        drive(OP_ADDI, 0, 0, 1);
        chk("to_halt",    32'(state_o), 32'(S_HALT));
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_illegal", 32'(illegal), 0);
        chk("to_we_halt", 32'({pcen, irwrite}), 0);
        @(negedge clk);

        // Undefined R-type funct
        do_rst();
        drive(OP_R, 6'b000111, 0, 1);
        @(negedge clk);
        drive(OP_R, 6'b000111, 0, 0);
        @(negedge clk);
        drive(OP_R, 6'b000111, 0, 0);
        chk("badf_state",   32'(state_o), 32'(S_HALT));
        chk("badf_illegal", 32'(illegal), 1);
        chk("badf_bus_err", 32'(bus_err), 0);

        // Reset in the middle of a store abandons it
        do_rst();
        drive(OP_SW, 0, 0, 1); @(negedge clk);
        drive(OP_SW, 0, 0, 0); @(negedge clk);
        drive(OP_SW, 0, 0, 0); @(negedge clk);
        drive(OP_SW, 0, 0, 0);
        chk("mid_memwr", 32'(state_o), 32'(S_MEMWR));
        reset_n = 1'b0;
        #1;
        chk("mid_state", 32'(state_o), 32'(S_FETCH));
        chk("mid_ctl",   32'(ctl_now()), 32'(C_FETCH_W));
        @(negedge clk);
        reset_n = 1'b1;

        // 17 back-to-back adds: instret wraps through 0 at 16
        for (int n = 0; n < 17; n++) begin
            for (int c = 0; c < 4; c++) begin
                drive(OP_R, 6'b100000, 0, 1);
                if (n == 16 && c == 0) begin
                    chk("wrap_instret", 32'(instret), cexp(16));
                    chk("wrap_cycles",  32'(cycles),  cexp(64));
                end
                @(negedge clk);
            end
        end
        drive(OP_R, 6'b100000, 0, 1);
        chk("wrap17_state",   32'(state_o), 32'(S_FETCH));
        chk("wrap17_instret", 32'(instret), cexp(17));
        chk("wrap17_cycles",  32'(cycles),  cexp(68));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
